// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file writeback path.
//   XLEN_DEFAULT   : default data width
//   REG_AW_DEFAULT : default register index width (2**REG_AW registers)
//   REG_ZERO       : index of the hardwired zero register
//   port_e         : writeback requester index (PORT_ALU = 0, PORT_LSU = 1)
package regfile_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic {
    PORT_ALU = 1'b0,
    PORT_LSU = 1'b1
  } port_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-request round-robin arbiter.
// Ports:
//   Clk, Reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector (bit N = port N)
//   gnt[1:0]   : one-hot grant, combinational; all zero while Reset is high
//   ptr        : priority pointer state (port that wins a tie next)
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_e      ptr
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt = 2'b00;
    if (!Reset) begin
      if (req == 2'b11) begin
        gnt = (ptr == PORT_ALU) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // After any grant the other port gets priority; idle cycles hold it.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr <= PORT_ALU;
    end else if (gnt[0]) begin
      ptr <= PORT_LSU;
    end else if (gnt[1]) begin
      ptr <= PORT_ALU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file write port between the ALU
// writeback (port 0) and load data (port 1), registering the winner into a
// one-deep stage that drives Rw/busW/RegWr. The register file commits on
// the falling edge of Clk in the cycle after acceptance.
//
// Handshake: a transfer happens on a rising edge where ReqNValid and
// ReqNReady are both high; a requester holds Valid/Rd/Data stable until
// accepted. ReqNReady is the combinational grant and is low during Reset.
//
// Ports:
//   Clk, Reset                    : clock, asynchronous active-high reset
//   Req0Valid/Rd/Data, Req0Ready  : port 0 (ALU) write request
//   Req1Valid/Rd/Data, Req1Ready  : port 1 (load) write request
//   Rw, busW, RegWr               : registered register-file write port
//   arb_ptr                       : debug view of the round-robin pointer
//   Ra, Rb, FwdA*/FwdB*           : bypass compare, present only when the
//                                   WB_BYPASS_EN macro is defined
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0Valid,
  input  logic [REG_AW-1:0] Req0Rd,
  input  logic [XLEN-1:0]   Req0Data,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [REG_AW-1:0] Req1Rd,
  input  logic [XLEN-1:0]   Req1Data,
  output logic              Req1Ready,
  output logic [REG_AW-1:0] Rw,
  output logic [XLEN-1:0]   busW,
  output logic              RegWr,
  output logic              arb_ptr
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] Ra,
  input  logic [REG_AW-1:0] Rb,
  output logic              FwdAValid,
  output logic              FwdBValid,
  output logic [XLEN-1:0]   FwdAData,
  output logic [XLEN-1:0]   FwdBData
`endif
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(REG_ZERO);

  logic [1:0] req;
  logic [1:0] gnt;
  port_e      ptr;

  assign req = {Req1Valid, Req0Valid};

  rr_arb2 u_arb (
    .Clk   (Clk),
    .Reset (Reset),
    .req   (req),
    .gnt   (gnt),
    .ptr   (ptr)
  );

  assign Req0Ready = gnt[0];
  assign Req1Ready = gnt[1];
  assign arb_ptr   = ptr;

  // Output stage: x0 writes are accepted but never raise RegWr. With no
  // grant only RegWr drops; Rw/busW keep their last value.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Rw    <= '0;
      busW  <= '0;
      RegWr <= 1'b0;
    end else if (gnt[0]) begin
      Rw    <= Req0Rd;
      busW  <= Req0Data;
      RegWr <= (Req0Rd != ZERO_IDX);
    end else if (gnt[1]) begin
      Rw    <= Req1Rd;
      busW  <= Req1Data;
      RegWr <= (Req1Rd != ZERO_IDX);
    end else begin
      RegWr <= 1'b0;
    end
  end

`ifdef WB_BYPASS_EN
  // Covers the first half of the write cycle, before the falling-edge commit.
  assign FwdAValid = RegWr && (Rw == Ra) && (Ra != ZERO_IDX);
  assign FwdBValid = RegWr && (Rw == Rb) && (Rb != ZERO_IDX);
  assign FwdAData  = busW;
  assign FwdBData  = busW;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int W      = 1 + REG_AW + XLEN;

  // ---------------- clock / reset ----------------
  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Req0Valid = 1'b0;
  logic [REG_AW-1:0] Req0Rd = '0;
  logic [XLEN-1:0]   Req0Data = '0;
  logic              Req0Ready;
  logic              Req1Valid = 1'b0;
  logic [REG_AW-1:0] Req1Rd = '0;
  logic [XLEN-1:0]   Req1Data = '0;
  logic              Req1Ready;
  logic [REG_AW-1:0] Rw;
  logic [XLEN-1:0]   busW;
  logic              RegWr;
  logic              arb_ptr;
`ifdef WB_BYPASS_EN
  logic [REG_AW-1:0] Ra = '0;
  logic [REG_AW-1:0] Rb = '0;
  logic              FwdAValid, FwdBValid;
  logic [XLEN-1:0]   FwdAData, FwdBData;
`endif

  always #5 Clk = ~Clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Req0Valid (Req0Valid),
    .Req0Rd    (Req0Rd),
    .Req0Data  (Req0Data),
    .Req0Ready (Req0Ready),
    .Req1Valid (Req1Valid),
    .Req1Rd    (Req1Rd),
    .Req1Data  (Req1Data),
    .Req1Ready (Req1Ready),
    .Rw        (Rw),
    .busW      (busW),
    .RegWr     (RegWr),
    .arb_ptr   (arb_ptr)
`ifdef WB_BYPASS_EN
    ,
    .Ra        (Ra),
    .Rb        (Rb),
    .FwdAValid (FwdAValid),
    .FwdBValid (FwdBValid),
    .FwdAData  (FwdAData),
    .FwdBData  (FwdBData)
`endif
  );

  // Register file fed by the DUT write port; commits on the falling edge.
  logic [XLEN-1:0] rf [32];
  always @(negedge Clk) begin
    if (RegWr && Rw != 0) rf[Rw] <= busW;
  end

  // ---------------- scoreboard / reference model ----------------
  logic [W-1:0]      exp_q[$];
  logic [XLEN-1:0]   exp_rf [32];
  logic              m_ptr;
  logic              m_we;
  logic [REG_AW-1:0] m_rw;
  logic [XLEN-1:0]   m_busw;
  int                vectors = 0;
  int                miscompares = 0;
  logic              g0, g1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 1'b0;
    m_we   = 1'b0;
    m_rw   = '0;
    m_busw = '0;
  endtask

  // ---------------- driver tasks ----------------
  // Present one cycle of requests, check the grants, predict the output
  // stage, then compare it one edge later.
  task automatic step(input logic v0, input logic [REG_AW-1:0] rd0, input logic [XLEN-1:0] d0,
                      input logic v1, input logic [REG_AW-1:0] rd1, input logic [XLEN-1:0] d1,
                      output logic eg0, output logic eg1);
    logic [W-1:0] e;
    Req0Valid = v0; Req0Rd = rd0; Req0Data = d0;
    Req1Valid = v1; Req1Rd = rd1; Req1Data = d1;
    #1;
    if (v0 && v1) begin
      eg0 = (m_ptr == 1'b0);
      eg1 = !eg0;
    end else begin
      eg0 = v0;
      eg1 = v1;
    end
    check("req0_ready", 64'(Req0Ready), 64'(eg0));
    check("req1_ready", 64'(Req1Ready), 64'(eg1));
    if (eg0) begin
      m_we = (rd0 != 0); m_rw = rd0; m_busw = d0; m_ptr = 1'b1;
    end else if (eg1) begin
      m_we = (rd1 != 0); m_rw = rd1; m_busw = d1; m_ptr = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    exp_q.push_back({m_we, m_rw, m_busw});
    @(posedge Clk);
    #1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    e = exp_q.pop_front();
    check("reg_wr", 64'(RegWr), 64'(e[W-1]));
    check("rw",     64'(Rw),    64'(e[W-2 -: REG_AW]));
    check("busw",   64'(busW),  64'(e[XLEN-1:0]));
    if (e[W-1]) exp_rf[e[W-2 -: REG_AW]] = e[XLEN-1:0];
  endtask

  task automatic rf_check(input logic [REG_AW-1:0] idx, input logic [XLEN-1:0] val);
    @(negedge Clk);
    #1;
    check($sformatf("rf[%0d]", idx), 64'(rf[idx]), 64'(val));
  endtask

  task automatic reset_dut();
    Reset = 1'b1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    model_reset();
    @(negedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic              p0v, p1v;
  logic [REG_AW-1:0] p0rd, p1rd;
  logic [XLEN-1:0]   p0d, p1d;

  initial begin
    for (int i = 0; i < 32; i++) begin
      rf[i] = '0;
      exp_rf[i] = '0;
    end
    model_reset();

    // Reset state, including Ready held low against a valid request.
    #2;
    check("rst_regwr", 64'(RegWr), 64'(0));
    check("rst_rw",    64'(Rw),    64'(0));
    check("rst_busw",  64'(busW),  64'(0));
    check("rst_ptr",   64'(arb_ptr), 64'(0));
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    #1;
    check("rst_ready0", 64'(Req0Ready), 64'(0));
    check("rst_ready1", 64'(Req1Ready), 64'(0));
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    @(negedge Clk);
    #1;
    Reset = 1'b0;

    // Port 0 alone: Rd=5, DEADBEEF; visible in the register file after the fall.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, g0, g1);
    rf_check(5, 32'hDEADBEEF);

    // Reset mid-stream while RegWr is high: accepted write is discarded.
    step(1, 10, 32'hCAFEF00D, 0, 0, 0, g0, g1);
    exp_rf[10] = '0;
    Req0Valid = 1'b1;
    Req1Valid = 1'b1;
    Reset = 1'b1;
    #1;
    check("mid_rst_regwr",  64'(RegWr),     64'(0));
    check("mid_rst_rw",     64'(Rw),        64'(0));
    check("mid_rst_busw",   64'(busW),      64'(0));
    check("mid_rst_ready0", 64'(Req0Ready), 64'(0));
    check("mid_rst_ready1", 64'(Req1Ready), 64'(0));
    model_reset();
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    @(negedge Clk);
    #1;
    Reset = 1'b0;
    check("rf10_discarded", 64'(rf[10]), 64'(0));
    step(0, 0, 0, 1, 3, 32'h0000_0333, g0, g1);

    // Both valid from reset: grants alternate 0,1,0,1 with held requests.
    reset_dut();
    step(1, 11, 32'hA000_0000, 1, 12, 32'hB000_0000, g0, g1);
    step(1, 13, 32'hA000_0001, 1, 12, 32'hB000_0000, g0, g1);
    step(1, 13, 32'hA000_0001, 1, 14, 32'hB000_0001, g0, g1);
    step(1, 15, 32'hA000_0002, 1, 14, 32'hB000_0001, g0, g1);

    // x0 write from port 1 still advances the pointer.
    step(1, 2, 32'h0000_0022, 0, 0, 0, g0, g1);
    check("ptr_after_p0", 64'(arb_ptr), 64'(m_ptr));
    step(0, 0, 0, 1, 0, 32'h0000_1234, g0, g1);
    check("ptr_after_x0", 64'(arb_ptr), 64'(m_ptr));
    step(1, 16, 32'h1600_0000, 1, 17, 32'h1700_0000, g0, g1);
    step(0, 0, 0, 1, 17, 32'h1700_0000, g0, g1);

    // Same-Rd race: last granted write wins.
    step(1, 9, 32'h1, 0, 0, 0, g0, g1);
    step(0, 0, 0, 1, 9, 32'h2, g0, g1);
    rf_check(9, 32'h2);

`ifdef WB_BYPASS_EN
    Ra = 7;
    Rb = 0;
    step(1, 7, 32'hA5A5A5A5, 0, 0, 0, g0, g1);
    check("fwd_a_valid", 64'(FwdAValid), 64'(1));
    check("fwd_a_data",  64'(FwdAData),  64'(32'hA5A5A5A5));
    check("fwd_b_valid", 64'(FwdBValid), 64'(0));
`endif

    // Idle: RegWr drops, Rw/busW hold.
    step(0, 0, 0, 0, 0, 0, g0, g1);

    // Random traffic with requesters that hold until accepted.
    p0v = 1'b0; p1v = 1'b0;
    p0rd = '0; p1rd = '0; p0d = '0; p1d = '0;
    for (int n = 0; n < 40; n++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1'b1; p0rd = REG_AW'($urandom_range(0, 31)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1'b1; p1rd = REG_AW'($urandom_range(0, 31)); p1d = $urandom;
      end
      step(p0v, p0rd, p0d, p1v, p1rd, p1d, g0, g1);
      if (g0) p0v = 1'b0;
      if (g1) p1v = 1'b0;
    end
    step(0, 0, 0, 0, 0, 0, g0, g1);
    @(negedge Clk);
    #1;
    for (int i = 1; i < 32; i++) begin
      check($sformatf("final_rf[%0d]", i), 64'(rf[i]), 64'(exp_rf[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between two writeback requesters: port 0 (ALU result) and port 1 (load data). Grants fairly with a 2-way round-robin and registers the winning write into a one-deep output stage. That stage drives the register file's Rw/busW/RegWr, and the register file commits on the falling edge of Clk.

## Interface
Parameters:
- XLEN, 32, data width.
- REG_AW, 5, register index width (2^REG_AW registers; index 0 is the hardwired zero).

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high.
- Req0Valid  in  1  port 0 has a write pending.
- Req0Rd  in  REG_AW  port 0 destination register.
- Req0Data  in  XLEN  port 0 write data.
- Req0Ready  out  1  port 0 accepted this cycle (combinational).
- Req1Valid  in  1  port 1 has a write pending.
- Req1Rd  in  REG_AW  port 1 destination register.
- Req1Data  in  XLEN  port 1 write data.
- Req1Ready  out  1  port 1 accepted this cycle (combinational).
- Rw  out  REG_AW  register file write index (registered).
- busW  out  XLEN  register file write data (registered).
- RegWr  out  1  register file write enable (registered).
- Ra, Rb  in  REG_AW each  read indices, for bypass (only with WB_BYPASS_EN).
- FwdAValid, FwdBValid  out  1 each  bypass hit (only with WB_BYPASS_EN).
- FwdAData, FwdBData  out  XLEN each  bypass data (only with WB_BYPASS_EN).

## Operation
- Handshake:
  - A transfer occurs on a rising edge where ReqNValid and ReqNReady are both high.
  - Once a requester raises Valid, it holds Valid, Rd and Data stable until accepted.
- Grant:
  - Exactly one port is granted per cycle when any Valid is high.
  - If only one port is valid, that port is granted.
  - If both are valid, the port selected by the priority pointer wins.
  - ReqNReady = grant to port N. No other backpressure exists; the output stage is overwritten every cycle.
- Priority pointer (1 bit, state):
  - After any grant, the pointer moves to the other port.
  - With no valid request, the pointer holds.
- Output stage, updated every rising edge:
  - On a grant: Rw <= granted Rd, busW <= granted Data, RegWr <= (granted Rd != 0).
  - With no grant: RegWr <= 0; Rw and busW hold.
- x0 writes: accepted, RegWr stays 0, and the pointer still advances.
- Reset (asynchronous):
  - Rw=0, busW=0, RegWr=0, pointer=port 0. A write accepted but not yet committed is discarded.
  - Ready outputs are 0 while Reset is high.

## Timing
- Request accepted at rising edge t. During cycle t+1, RegWr/Rw/busW are valid; the register file commits at the falling edge mid-cycle t+1.
- Combinational reads see the new value from the falling edge in cycle t+1 onward.
- Throughput: one write per cycle.
- Worst-case wait for a continuously valid port: 1 cycle.
- Back-to-back writes to the same Rd from alternating ports commit in grant order; the last granted write wins.

## Configuration
- WB_BYPASS_EN defined:
  - FwdAValid = RegWr && Rw==Ra && Ra!=0, with FwdAData = busW (same rule for B with Rb).
  - These outputs are purely combinational and cover the first half of cycle t+1, before the falling-edge commit.
- WB_BYPASS_EN undefined:
  - Ra, Rb and all Fwd* ports are absent.
  - Readers see the new value only after the falling-edge commit.

## Structure
- Shared package regfile_pkg:
  - XLEN and REG_AW defaults.
  - REG_ZERO constant (index 0).
  - Port-index type (PORT_ALU=0, PORT_LSU=1).
- Sub-module rr_arb2:
  - 2-request round-robin with pointer state.
  - Inputs Clk, Reset, req[1:0]; outputs gnt[1:0].
- The top level holds the output stage and the optional bypass compare.

## Test plan
- Reset asserted mid-stream with RegWr=1 -> RegWr, Rw and busW go to 0 immediately; after release, first Req1Valid (Rd=3) is granted with Req1Ready=1.
- Port 0 alone writes Rd=5, Data=0xDEADBEEF at edge t -> during t+1: RegWr=1, Rw=5, busW=0xDEADBEEF; register 5 reads 0xDEADBEEF after the falling edge.
- Both ports valid for 4 cycles, starting from reset -> grants alternate 0,1,0,1, and each port's Ready pulses every other cycle.
- Port 1 writes Rd=0, Data=0x1234 -> Req1Ready=1, RegWr stays 0, the pointer advances, and register 0 still reads 0.
- WB_BYPASS_EN: write Rd=7, Data=0xA5A5A5A5 with Ra=7, Rb=0 -> in cycle t+1, FwdAValid=1 and FwdAData=0xA5A5A5A5; FwdBValid=0.
- Same-Rd race: port 0 writes Rd=9, Data=1, then port 1 writes Rd=9, Data=2 on the next edge -> register 9 ends at 2.
